// File: rtl/mix_stream_checker.sv
// Purpose: receive-side checker; regenerates 8 mixed lanes and compares them against the incoming word stream.
// Latency: start->busy 1 cycle; MIX takes 32 cycles, then in_ready is high; counters update on the handshake edge.
// Backpressure: in_ready is registered and high for all of CMP; in_valid gaps hold the lane counter.
// Optional feature: define MIXCHK_RESYNC_EN to overwrite a mismatching lane with the received word.
module mix_stream_checker #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             en,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   output logic             in_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err,
   output logic [2:0]       first_err_lane
);

   typedef enum logic [1:0] {IDLE, MIX, CMP} state_t;

   localparam int K_TAB [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
   localparam int C_TAB [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

   state_t       state, state_nxt;
   logic [4:0]   step;      // [4:3] selects step A..D, [2:0] is the lane being updated
   logic [2:0]   lane;      // lane expected on the next handshake
   logic [W-1:0] s [8];
   logic [W-1:0] upd;
   logic [2:0]   idx;
   logic         hs;
   logic         mism;

   assign busy = (state != IDLE);
   assign hs   = in_valid && in_ready;
   assign mism = hs && (in_data != s[lane]);
   assign idx  = step[2:0];

   // Next-state logic: one round of 32 updates, then 8 accepted beats, then chain or stop.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = MIX;
         MIX:     if (step == 5'd31) state_nxt = CMP;
         CMP:     if (hs && (lane == 3'd7)) state_nxt = en ? MIX : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Single-lane update value; lower lanes are already updated, so the round is strictly sequential.
   always_comb begin
      upd = s[idx];
      case (step[4:3])
         2'd0:    upd = s[idx] + W'(idx);
         2'd1:    upd = s[idx] + s[idx - 3'd1];
         2'd2:    upd = s[idx] ^ (s[idx + 3'd3] << 16);
         default: upd = s[idx] * W'(K_TAB[idx]) + W'(C_TAB[idx]);
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Datapath: lane state, step/lane counters, registered ready, counters and error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step           <= '0;
         lane           <= '0;
         in_ready       <= 1'b0;
         frame_cnt      <= '0;
         err_cnt        <= '0;
         err            <= 1'b0;
         first_err_lane <= '0;
         for (int i = 0; i < 8; i++) s[i] <= '0;
      end else begin
         in_ready <= (state_nxt == CMP);
         case (state)
            IDLE: begin
               if (start) begin
                  step           <= '0;
                  lane           <= '0;
                  frame_cnt      <= '0;
                  err_cnt        <= '0;
                  err            <= 1'b0;
                  first_err_lane <= '0;
                  for (int i = 0; i < 8; i++) s[i] <= W'(i);
               end
            end
            MIX: begin
               s[idx] <= upd;
               step   <= step + 5'd1;
            end
            CMP: begin
               if (hs) begin
                  lane <= lane + 3'd1;
                  if (lane == 3'd7 && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
                  if (mism) begin
                     err <= 1'b1;
                     if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                     if (!err) first_err_lane <= lane;
`ifdef MIXCHK_RESYNC_EN
                     s[lane] <= in_data;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_stream_checker.sv
// Scoreboard bench for mix_stream_checker: randomized gaps and corruptions against a round-level model.
// Stimulus pushes expected counter state per beat; a negedge monitor pops on each completed handshake.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_mix_stream_checker;

   typedef logic [7:0][31:0] st_t;
   typedef struct {
      int ec;
      bit e;
      int fc;
      int fel;
      int sec;
   } exp_t;

   localparam int KT [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
   localparam int CT [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

   logic        clk = 1'b0;
   logic        rst_n, start, en, in_valid;
   logic [31:0] in_data;
   logic        in_ready, busy, err;
   logic [15:0] frame_cnt, err_cnt;
   logic [2:0]  first_err_lane;
   logic        in_ready_s, busy_s, err_s;
   logic [1:0]  frame_cnt_s, err_cnt_s;
   logic [2:0]  first_err_lane_s;

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];
   bit   pend = 1'b0;

   st_t  ms, gs;   // ms: checker's expected state, gs: sender's state
   int   m_ec, m_fc, m_fel, m_sec;
   bit   m_e;

   always #5 clk = ~clk;

   mix_stream_checker #(.W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .en(en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err(err), .first_err_lane(first_err_lane));

   mix_stream_checker #(.W(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .en(en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s), .busy(busy_s),
      .frame_cnt(frame_cnt_s), .err_cnt(err_cnt_s), .err(err_s), .first_err_lane(first_err_lane_s));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // One mixing round straight from the arithmetic rules.
   function automatic st_t mix_round(input st_t a);
      for (int i = 0; i < 8; i++) a[i] = a[i] + 32'(i);
      for (int i = 0; i < 8; i++) a[i] = a[i] + a[(i + 7) % 8];
      for (int i = 0; i < 8; i++) a[i] = a[i] ^ (a[(i + 3) % 8] << 16);
      for (int i = 0; i < 8; i++) a[i] = a[i] * 32'(KT[i]) + 32'(CT[i]);
      return a;
   endfunction

   // Monitor: outputs after a handshake edge are compared at the following negedge.
   always @(negedge clk) begin
      exp_t x;
      if (pend) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            x = q.pop_front();
            check("sb_err_cnt", 64'(err_cnt), 64'(x.ec));
            check("sb_err", 64'(err), 64'(x.e));
            check("sb_frame_cnt", 64'(frame_cnt), 64'(x.fc));
            check("sb_first_err_lane", 64'(first_err_lane), 64'(x.fel));
            check("sb_sat_err_cnt", 64'(err_cnt_s), 64'(x.sec));
         end
      end
      pend = in_valid && in_ready && rst_n;
   end

   task automatic model_beat(input int ln, input logic [31:0] d);
      exp_t x;
      if (d != ms[ln]) begin
         if (!m_e) m_fel = ln;
         m_e = 1'b1;
         if (m_ec < 65535) m_ec++;
         if (m_sec < 3) m_sec++;
`ifdef MIXCHK_RESYNC_EN
         ms[ln] = d;
`endif
      end
      if (ln == 7) m_fc++;
      x.ec = m_ec; x.e = m_e; x.fc = m_fc; x.fel = m_fel; x.sec = m_sec;
      q.push_back(x);
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic send_beat(input int ln, input logic [31:0] d, input int gap);
      int n = 0;
      in_valid = 1'b0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("ready_timeout", 64'(in_ready), 64'(1));
         return;
      end
      repeat (gap) begin
         check("ready_during_gap", 64'(in_ready), 64'(1));
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      model_beat(ln, d);
      @(posedge clk); #1;
   endtask

   // corrupt: -1 none, 0..7 flip bit 0 of that lane, 8 invert every lane.
   task automatic run_frame(input int nlanes, input int corrupt, input int max_gap, input bit kat);
      logic [31:0] d;
      logic [31:0] kv [3];
      kv[0] = 32'h0034001F; kv[1] = 32'h00660035; kv[2] = 32'h00DC006B;
      gs = mix_round(gs);
      ms = mix_round(ms);
      for (int ln = 0; ln < nlanes; ln++) begin
         d = (kat && ln < 3) ? kv[ln] : gs[ln];
         if (corrupt == ln) d = d ^ 32'h1;
         if (corrupt == 8) d = ~d;
         gs[ln] = d;
         send_beat(ln, d, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      end
      in_valid = 1'b0;
   endtask

   // Start pulse; optionally a second pulse extra_at cycles later (ignored by the DUT).
   task automatic start_run(input int extra_at);
      int n = 0;
      for (int i = 0; i < 8; i++) begin
         gs[i] = 32'(i);
         ms[i] = 32'(i);
      end
      m_ec = 0; m_fc = 0; m_fel = 0; m_sec = 0; m_e = 1'b0;
      in_valid = 1'b0;
      start    = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
         start = (n == extra_at);
         if (n == 1) check("busy_after_start", 64'(busy), 64'(1));
      end while (!in_ready && n < 200);
      start = 1'b0;
      check("ready_latency", 64'(n), 64'(33));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
      check({tag, "_err"}, 64'(err), 64'(0));
      check({tag, "_first_err_lane"}, 64'(first_err_lane), 64'(0));
      check({tag, "_sat_err_cnt"}, 64'(err_cnt_s), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer frame, back-to-back beats, then a chained frame with gaps that ends the run.
      en = 1'b1;
      start_run(0);
      run_frame(8, -1, 0, 1'b1);
      check("kat_err", 64'(err), 64'(0));
      check("kat_frame_cnt", 64'(frame_cnt), 64'(1));
      en = 1'b0;
      run_frame(8, -1, 3, 1'b0);
      check("chain_busy_end", 64'(busy), 64'(0));
      check("chain_ready_end", 64'(in_ready), 64'(0));
      check("chain_frame_cnt", 64'(frame_cnt), 64'(2));

      // Single corrupted word in frame 1, then a stream continuing from the corrupted sender state.
      en = 1'b1;
      start_run(0);
      run_frame(8, 2, 0, 1'b0);
      check("corrupt_err_cnt", 64'(err_cnt), 64'(1));
      check("corrupt_fel", 64'(first_err_lane), 64'(2));
      en = 1'b0;
      run_frame(8, -1, 2, 1'b0);
`ifdef MIXCHK_RESYNC_EN
      check("resync_err_cnt", 64'(err_cnt), 64'(1));
`else
      check("propagate_err_cnt_gt1", 64'(err_cnt > 16'd1), 64'(1));
`endif
      check("corrupt_err_sticky", 64'(err), 64'(1));

      // en low for frame 1 with a stray start mid-MIX and random gaps.
      en = 1'b0;
      start_run(10);
      run_frame(8, -1, 3, 1'b0);
      check("stop_busy", 64'(busy), 64'(0));
      check("stop_frame_cnt", 64'(frame_cnt), 64'(1));

      // Reset asserted with the lane counter at 4, then a clean rerun.
      start_run(0);
      run_frame(4, -1, 1, 1'b0);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_run(0);
      run_frame(8, -1, 0, 1'b1);
      check("rerun_err", 64'(err), 64'(0));
      check("rerun_frame_cnt", 64'(frame_cnt), 64'(1));

      // Every word wrong: the 2-bit counter saturates at 3.
      start_run(0);
      run_frame(8, 8, 1, 1'b0);
      check("allbad_err_cnt", 64'(err_cnt), 64'(8));
      check("sat_err_cnt", 64'(err_cnt_s), 64'(3));
      check("sat_err", 64'(err_s), 64'(1));
      check("allbad_fel", 64'(first_err_lane), 64'(0));

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 64'(q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mix_stream_checker.md
# mix_stream_checker

Receiving-end checker for the 8-lane, 32-bit mixing stream. It regenerates the expected lane values locally with a sequential mixing engine and compares them against incoming words on a valid/ready stream. It also counts frames and mismatches. It sits at the sink of the mixing-datapath test harness, and its counters and sticky error flag feed the pass/fail status.

## Interface
- `W`, default 32: lane width; all arithmetic is modulo 2^W.
- `CNT_W`, default 16: width of the frame and error counters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; honoured only in IDLE.
- `en` in 1: level; keeps the checker running frame after frame.
- `in_valid` in 1: the input word is valid.
- `in_data` in W: received word; the lane index is implicit (beat 0..7 of the frame).
- `in_ready` out 1: the checker accepts a word.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_cnt` out CNT_W: completed frames; saturates at all-ones.
- `err_cnt` out CNT_W: mismatching words; saturates at all-ones.
- `err` out 1: sticky, set on any mismatch.
- `first_err_lane` out 3: lane of the first mismatch since `start`.

## Operation
- State vector `s[0..7]`, each W bits. `start` loads `s[i] = i`, clears the counters, `err` and `first_err_lane`, and then enters MIX.
- MIX runs one round as 32 single-lane updates, one per cycle. Each update uses the already-updated lower lanes, so the order is strictly sequential.
  - Step A, i = 0..7: `s[i] = s[i] + i`.
  - Step B, i = 0..7: `s[i] = s[i] + s[(i+7)%8]`.
  - Step C, i = 0..7: `s[i] = s[i] ^ (s[(i+3)%8] << 16)`; bits shifted past W are discarded.
  - Step D, i = 0..7: `s[i] = s[i]*K[i] + C[i]`, truncated to W.
    - K = {2,3,5,7,11,13,17,19}
    - C = {3,5,7,11,13,17,19,23}
- CMP: `in_ready` = 1 and a lane counter runs 0..7. On each handshake (`in_valid && in_ready`):
  - Compare `in_data` against `s[lane]`.
  - On mismatch, increment `err_cnt` and set `err`. If `err` was previously clear, record `first_err_lane`.
- After lane 7 is accepted, `frame_cnt` increments. Then:
  - `en` = 1: go to MIX for the next round, which chains from the current `s`.
  - `en` = 0: go to IDLE.
- The states are IDLE → MIX (`start`) → CMP (after 32 cycles) → MIX or IDLE.
- `start` outside IDLE is ignored. `en` is sampled only at the end of a frame.

## Timing
- Reset values: `in_ready` = 0, `busy` = 0, `frame_cnt` = 0, `err_cnt` = 0, `err` = 0, `first_err_lane` = 0, state IDLE, `s` = 0.
- `start` at edge N gives `busy` = 1 from N+1.
- MIX occupies 32 cycles, and `in_ready` rises on the cycle after the last update.
- With `in_valid` held high, CMP lasts 8 cycles, so a frame takes 40 cycles.
- `in_ready` is registered and stays high throughout CMP, independent of `in_valid`. Stalls (`in_valid` = 0) simply hold the lane counter.
- Counters and `err` update on the edge that completes the handshake. `frame_cnt` updates on the lane-7 handshake edge.
- If a mismatch and a saturated `err_cnt` coincide, the counter holds and `err` is still set.
- Reset asserted mid-frame: everything returns to reset values immediately. No partial frame is counted.

## Configuration
- `MIXCHK_RESYNC_EN` defined: on a mismatch, `s[lane]` is overwritten with `in_data`. The next round then continues from the received stream, so a single corrupted word produces exactly one error.
- Not defined: `s` is never modified by input, so a corruption propagates into later frames.

## Test plan
- Reset, then `start`, `en` = 1, and feed the correct words:
  - Frame 1 lane 0 = 0x0034001F, lane 1 = 0x00660035, lane 2 = 0x00DC006B.
  - Result: `err` = 0 and `frame_cnt` = 1 after the 8th beat. `in_ready` first goes high exactly 33 cycles after the `start` edge.
- Frame 1 with lane 2 sent as 0x00DC006A: `err_cnt` = 1, `err` = 1, `first_err_lane` = 2.
  - With `MIXCHK_RESYNC_EN`: a correct frame 2 stream (generated from the corrupted state) gives `err_cnt` still 1.
  - Without it: the same stream gives `err_cnt` > 1.
- Insert random `in_valid` gaps during CMP: same counts as the gap-free run, and `in_ready` stays high throughout CMP.
- `en` = 0 during frame 1: IDLE after lane 7, `busy` = 0, `frame_cnt` = 1. A `start` pulse mid-MIX has no effect.
- Assert `rst_n` low during CMP lane 4: all outputs return to their reset values. A new `start` then reproduces frame 1 values.
- Force `err_cnt` to saturation with continuous mismatches (`CNT_W` = 2): it holds at 3 and `err` stays 1.
